wb_dfx_rm_decoupler: RTL and testbench

Wishbone decoupler and shutdown-handshake stage between the system crossbar and the reconfigurable module (RM) in virtual socket VS_0. Consumes the DFX controller's `rm_shutdown_req` / `rm_decouple` and produces `rm_shutdown_ack` once all in-flight RM bus transactions have drained, or once a timeout expires. While the RM is decoupled, the block isolates the RM port and answers bus accesses locally, so a partial bitstream load never hangs the crossbar.

---
 rtl/wb_dfx_pkg.sv | 21 ++
 rtl/wb_dfx_rm_decoupler_timer.sv | 39 +++
 rtl/wb_dfx_rm_decoupler.sv | 183 ++++++++++++++++++
 tb/tb_wb_dfx_rm_decoupler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dfx_pkg.sv
// Shared types and constants for the VS_0 reconfigurable-module decoupler.
// State encoding, the read pattern returned while the RM is isolated, and the
// local response encodings.
package wb_dfx_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DRAIN     = 2'd1,
        ACKED     = 2'd2,
        DECOUPLED = 2'd3
    } rm_dcpl_state_t;

    // Read data answered locally while the RM is isolated (ack mode).
    localparam logic [31:0] DECOUPLED_RDATA = 32'hDEC0_DEC0;

    // Local response kinds held in the response register.
    localparam logic [1:0] WB_RESP_NONE = 2'b00;
    localparam logic [1:0] WB_RESP_ACK  = 2'b01;
    localparam logic [1:0] WB_RESP_ERR  = 2'b10;

endpackage

// File: rtl/wb_dfx_rm_decoupler_timer.sv
// Drain timeout counter. Held at zero while clear is high, counts while en is
// high and saturates at TIMEOUT_CYCLES-1, where expired is asserted.
module wb_dfx_drain_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LAST);

    // Next count: clear wins, otherwise count up until the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_dfx_rm_decoupler.sv
// Wishbone decoupler / shutdown handshake between the crossbar and the RM in
// VS_0. Drains in-flight RM transactions before acknowledging a shutdown and
// answers crossbar accesses locally while the RM is isolated.
// Build option: define WB_DFX_DECOUPLER_ERR_EN to answer decoupled accesses
// with wbs_err instead of wbs_ack + DECOUPLED_RDATA.
// Handshake: a strobe is accepted on a cycle where stb is high and stall is
// low; every accepted strobe receives exactly one ack or err later.
module wb_dfx_rm_decoupler
    import wb_dfx_pkg::*;
#(
    parameter int ADR_W           = 28,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [ADR_W-1:0]                         wbs_adr,
    input  logic [31:0]                              wbs_dat_w,
    input  logic [3:0]                               wbs_sel,
    input  logic                                     wbs_we,
    input  logic                                     wbs_cyc,
    input  logic                                     wbs_stb,
    output logic [31:0]                              wbs_dat_r,
    output logic                                     wbs_ack,
    output logic                                     wbs_err,
    output logic                                     wbs_stall,
    output logic [ADR_W-1:0]                         wbm_adr_o,
    output logic [31:0]                              wbm_dat_o,
    output logic [3:0]                               wbm_sel_o,
    output logic                                     wbm_we_o,
    output logic                                     wbm_cyc_o,
    output logic                                     wbm_stb_o,
    input  logic [31:0]                              wbm_dat_i,
    input  logic                                     wbm_ack_i,
    input  logic                                     wbm_err_i,
    input  logic                                     wbm_stall_i,
    input  logic                                     rm_shutdown_req,
    input  logic                                     rm_decouple,
    output logic                                     rm_shutdown_ack,
    output logic                                     drain_timeout,
    output logic                                     decoupled,
    output rm_dcpl_state_t                           dbg_state,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     dbg_outst
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    rm_dcpl_state_t state_q, state_d;
    logic [OW-1:0]  outst_q, outst_d, outst_nto;
    logic           outst_inc, outst_dec;
    logic           shutdown_ack_q, shutdown_ack_d;
    logic           decoupled_q, decoupled_d;
    logic [1:0]     resp_q, resp_d;
    logic [31:0]    rdat_q, rdat_d;
    logic           rsp_fwd;
    logic           tmr_expired;

    // Address, data, sel and we always flow through; only strobes are gated.
    assign wbm_adr_o = wbs_adr;
    assign wbm_dat_o = wbs_dat_w;
    assign wbm_sel_o = wbs_sel;
    assign wbm_we_o  = wbs_we;

    // RM responses are only meaningful while the RM is still connected.
    assign rsp_fwd = (state_q == RUN) || (state_q == DRAIN);

    wb_dfx_drain_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != DRAIN),
        .en     (state_q == DRAIN),
        .expired(tmr_expired)
    );

    // In-flight count after this cycle's issues/responses, before any timeout.
    always_comb begin
        outst_inc = (state_q == RUN) && wbs_stb && (outst_q < OUT_MAX) && !wbm_stall_i;
        outst_dec = rsp_fwd && (wbm_ack_i || wbm_err_i) && (outst_q != '0);
        outst_nto = outst_q;
        if (!wbs_cyc) begin
            outst_nto = '0;
        end else if (outst_inc && !outst_dec) begin
            outst_nto = outst_q + OW'(1);
        end else if (!outst_inc && outst_dec) begin
            outst_nto = outst_q - OW'(1);
        end
    end

    // State transitions and RM-side strobe gating.
    always_comb begin
        state_d       = state_q;
        outst_d       = outst_nto;
        wbm_cyc_o     = 1'b0;
        wbm_stb_o     = 1'b0;
        wbs_stall     = 1'b1;
        drain_timeout = 1'b0;
        case (state_q)
            RUN: begin
                wbm_cyc_o = wbs_cyc;
                wbm_stb_o = wbs_stb && (outst_q < OUT_MAX);
                wbs_stall = wbm_stall_i || (outst_q == OUT_MAX);
                if (rm_shutdown_req || rm_decouple) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                wbm_cyc_o = wbs_cyc && (outst_q != '0);
                // Leave as soon as the last response of this cycle empties the count.
                if (outst_nto == '0) begin
                    state_d = ACKED;
                end else if (tmr_expired) begin
                    state_d       = ACKED;
                    drain_timeout = 1'b1;
                    outst_d       = '0;
                end
            end
            ACKED: begin
                if (rm_decouple) begin
                    state_d = DECOUPLED;
                end else if (!rm_shutdown_req) begin
                    state_d = RUN;
                end
            end
            DECOUPLED: begin
                wbs_stall = 1'b0;
                if (!rm_decouple) begin
                    state_d = rm_shutdown_req ? ACKED : RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Local response for strobes accepted while decoupled.
    always_comb begin
        resp_d = WB_RESP_NONE;
        rdat_d = 32'h0;
        if ((state_q == DECOUPLED) && wbs_cyc && wbs_stb) begin
`ifdef WB_DFX_DECOUPLER_ERR_EN
            resp_d = WB_RESP_ERR;
`else
            resp_d = WB_RESP_ACK;
            rdat_d = wbs_we ? 32'h0 : DECOUPLED_RDATA;
`endif
        end
    end

    assign shutdown_ack_d = (state_d == ACKED) || (state_d == DECOUPLED);
    assign decoupled_d    = (state_d == DECOUPLED);

    // State, count and registered handshake/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            outst_q        <= '0;
            shutdown_ack_q <= 1'b0;
            decoupled_q    <= 1'b0;
            resp_q         <= WB_RESP_NONE;
            rdat_q         <= 32'h0;
        end else begin
            state_q        <= state_d;
            outst_q        <= outst_d;
            shutdown_ack_q <= shutdown_ack_d;
            decoupled_q    <= decoupled_d;
            resp_q         <= resp_d;
            rdat_q         <= rdat_d;
        end
    end

    assign wbs_ack   = (rsp_fwd && wbm_ack_i) || (resp_q == WB_RESP_ACK);
    assign wbs_err   = (rsp_fwd && wbm_err_i) || (resp_q == WB_RESP_ERR);
    assign wbs_dat_r = (resp_q != WB_RESP_NONE) ? rdat_q :
                       (rsp_fwd ? wbm_dat_i : 32'h0);

    assign rm_shutdown_ack = shutdown_ack_q;
    assign decoupled       = decoupled_q;
    assign dbg_state       = state_q;
    assign dbg_outst       = outst_q;

endmodule

// File: tb/tb_wb_dfx_rm_decoupler.sv
// Bench for wb_dfx_rm_decoupler (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=16).
// Honours WB_DFX_DECOUPLER_ERR_EN for the expected decoupled responses.
module tb_wb_dfx_rm_decoupler;
  import wb_dfx_pkg::*;

  localparam int ADR_W = 28;

  logic clk, rst_n;
  logic [ADR_W-1:0] wbs_adr;
  logic [31:0] wbs_dat_w, wbs_dat_r;
  logic [3:0] wbs_sel;
  logic wbs_we, wbs_cyc, wbs_stb, wbs_ack, wbs_err, wbs_stall;
  logic [ADR_W-1:0] wbm_adr_o;
  logic [31:0] wbm_dat_o, wbm_dat_i;
  logic [3:0] wbm_sel_o;
  logic wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_stall_i;
  logic rm_shutdown_req, rm_decouple, rm_shutdown_ack, drain_timeout, decoupled;
  rm_dcpl_state_t dbg_state;
  logic [2:0] dbg_outst;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  // {check_data, err, data}
  logic [33:0] exp_q[$];
  logic [ADR_W-1:0] rm_adr_q[$];
  int rm_due_q[$];
  logic rm_hold, rm_flush;
  int rm_lat;
  logic acc_stb, acc_we;
  logic [ADR_W-1:0] acc_adr;
  logic [31:0] acc_dat;

  wb_dfx_rm_decoupler #(.ADR_W(ADR_W), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_adr(wbs_adr), .wbs_dat_w(wbs_dat_w), .wbs_sel(wbs_sel), .wbs_we(wbs_we),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb),
    .wbs_dat_r(wbs_dat_r), .wbs_ack(wbs_ack), .wbs_err(wbs_err), .wbs_stall(wbs_stall),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_stall_i(wbm_stall_i),
    .rm_shutdown_req(rm_shutdown_req), .rm_decouple(rm_decouple),
    .rm_shutdown_ack(rm_shutdown_ack), .drain_timeout(drain_timeout), .decoupled(decoupled),
    .dbg_state(dbg_state), .dbg_outst(dbg_outst)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rm_data(input logic [ADR_W-1:0] a);
    return {4'hA, a};
  endfunction

  // ---------------- RM responder model ----------------
  initial begin
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = 32'h0; wbm_stall_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      wbm_ack_i = 1'b0;
      wbm_dat_i = 32'h0;
      if (rm_flush) begin
        rm_adr_q.delete();
        rm_due_q.delete();
      end else if (!rm_hold && rm_due_q.size() > 0 && rm_due_q[0] <= cyc_cnt) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = rm_data(rm_adr_q.pop_front());
        rm_due_q.delete(0);
      end
      @(negedge clk);
      if (!rm_flush && wbm_cyc_o && wbm_stb_o && !wbm_stall_i) begin
        rm_adr_q.push_back(wbm_adr_o);
        rm_due_q.push_back(cyc_cnt + rm_lat);
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  // Drive one strobe and hold it until accepted (bounded).
  task automatic wb_req(input logic [ADR_W-1:0] adr, input logic we, input logic [31:0] dat);
    logic ok;
    ok = 1'b0;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_adr = adr; wbs_we = we; wbs_dat_w = dat; wbs_sel = 4'hF;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = !wbs_stall;
      if (ok) begin
        acc_stb = wbm_stb_o; acc_we = wbm_we_o; acc_adr = wbm_adr_o; acc_dat = wbm_dat_o;
      end
      next_cycle();
    end
    wbs_stb = 1'b0;
    check("req_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_resp(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      next_cycle();
      n++;
    end
    check("resp_drain", exp_q.size(), 0);
  endtask

  // ---------------- main sequence + monitor ----------------
  initial begin
    int n0;
    int n;
    logic [33:0] e;
    rst_n = 1'b0;
    wbs_adr = '0; wbs_dat_w = 32'h0; wbs_sel = 4'h0; wbs_we = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
    rm_shutdown_req = 1'b0; rm_decouple = 1'b0;
    rm_hold = 1'b0; rm_flush = 1'b0; rm_lat = 3;
    acc_stb = 1'b0; acc_we = 1'b0; acc_adr = '0; acc_dat = 32'h0;

    // response monitor: pops one expectation per DUT response
    fork
      forever begin
        @(negedge clk);
        if (rst_n && (wbs_ack || wbs_err)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'({wbs_err, wbs_ack}), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("resp_kind", 32'({wbs_err, wbs_ack}), e[32] ? 32'd2 : 32'd1);
            if (e[33]) check("resp_data", wbs_dat_r, e[31:0]);
          end
        end
      end
    join_none

    // reset values
    repeat (2) @(negedge clk);
    check("rst_shutdown_ack", 32'(rm_shutdown_ack), 0);
    check("rst_drain_timeout", 32'(drain_timeout), 0);
    check("rst_decoupled", 32'(decoupled), 0);
    check("rst_wbs_ack", 32'(wbs_ack), 0);
    check("rst_wbs_err", 32'(wbs_err), 0);
    check("rst_wbs_dat_r", wbs_dat_r, 0);
    check("rst_state", 32'(dbg_state), 32'(RUN));
    check("rst_outst", 32'(dbg_outst), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    next_cycle();

    // passthrough: 3 pipelined reads, RM answers 3 cycles after accept
    rm_lat = 3;
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 1'b0, rm_data(28'h100 + 28'(i))});
    for (int i = 0; i < 3; i++) wb_req(28'h100 + 28'(i), 1'b0, 32'h0);
    @(negedge clk);
    check("pt_outst_peak", 32'(dbg_outst), 3);
    next_cycle();
    wait_resp(20);
    @(negedge clk);
    check("pt_outst_end", 32'(dbg_outst), 0);
    next_cycle();

    // drain: 2 outstanding, shutdown request, RM answers 6 cycles after accept
    rm_lat = 6;
    n0 = cyc_cnt;
    exp_q.push_back({1'b1, 1'b0, rm_data(28'h110)});
    exp_q.push_back({1'b1, 1'b0, rm_data(28'h111)});
    wb_req(28'h110, 1'b0, 32'h0);
    wb_req(28'h111, 1'b0, 32'h0);
    rm_shutdown_req = 1'b1;
    @(negedge clk);
    check("dr_stall_before", 32'(wbs_stall), 0);
    next_cycle();
    @(negedge clk);
    check("dr_stall_next", 32'(wbs_stall), 1);
    check("dr_state", 32'(dbg_state), 32'(DRAIN));
    check("dr_cyc_held", 32'(wbm_cyc_o), 1);
    while (cyc_cnt < n0 + 7) next_cycle();
    @(negedge clk);
    check("dr_ack_at_last_rsp", 32'(rm_shutdown_ack), 0);
    next_cycle();
    @(negedge clk);
    check("dr_ack_after_last_rsp", 32'(rm_shutdown_ack), 1);
    check("dr_state_acked", 32'(dbg_state), 32'(ACKED));
    check("dr_no_timeout", 32'(drain_timeout), 0);
    next_cycle();
    rm_shutdown_req = 1'b0;
    @(negedge clk);
    check("dr_ack_hold", 32'(rm_shutdown_ack), 1);
    next_cycle();
    @(negedge clk);
    check("dr_ack_release", 32'(rm_shutdown_ack), 0);
    check("dr_state_run", 32'(dbg_state), 32'(RUN));
    check("dr_resp_done", exp_q.size(), 0);
    next_cycle();

    // timeout: 1 outstanding, RM silent
    rm_hold = 1'b1;
    rm_lat = 1;
    n0 = cyc_cnt;
    wb_req(28'h300, 1'b0, 32'h0);
    rm_shutdown_req = 1'b1;
    while (cyc_cnt < n0 + 16) next_cycle();
    @(negedge clk);
    check("to_pulse_early", 32'(drain_timeout), 0);
    next_cycle();
    @(negedge clk);
    check("to_pulse", 32'(drain_timeout), 1);
    check("to_state_drain", 32'(dbg_state), 32'(DRAIN));
    next_cycle();
    @(negedge clk);
    check("to_pulse_end", 32'(drain_timeout), 0);
    check("to_shutdown_ack", 32'(rm_shutdown_ack), 1);
    check("to_state_acked", 32'(dbg_state), 32'(ACKED));
    check("to_outst_clr", 32'(dbg_outst), 0);
    next_cycle();
    rm_hold = 1'b0;
    @(negedge clk);
    check("to_late_ack_dropped", 32'(wbs_ack), 0);
    check("to_outst_stays", 32'(dbg_outst), 0);
    next_cycle();
    rm_shutdown_req = 1'b0;
    next_cycle();
    @(negedge clk);
    check("to_state_run", 32'(dbg_state), 32'(RUN));
    next_cycle();

    // decoupled access
    rm_decouple = 1'b1;
    n = 0;
    while (!decoupled && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("dc_enter", 32'(decoupled), 1);
    check("dc_state", 32'(dbg_state), 32'(DECOUPLED));
    check("dc_shutdown_ack", 32'(rm_shutdown_ack), 1);
    check("dc_stall", 32'(wbs_stall), 0);
    next_cycle();
`ifdef WB_DFX_DECOUPLER_ERR_EN
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    exp_q.push_back({1'b0, 1'b1, 32'h0});
`else
    exp_q.push_back({1'b1, 1'b0, 32'hDEC0_DEC0});
    exp_q.push_back({1'b0, 1'b0, 32'h0});
`endif
    wb_req(28'h200, 1'b0, 32'h0);
    check("dc_stb_gated", 32'(acc_stb), 0);
    wb_req(28'h201, 1'b1, 32'h1234_5678);
    @(negedge clk);
    check("dc_b2b_resp", 32'(wbs_ack | wbs_err), 1);
    check("dc_wbm_stb", 32'(wbm_stb_o), 0);
    check("dc_wbm_cyc", 32'(wbm_cyc_o), 0);
    next_cycle();
    @(negedge clk);
    check("dc_resp_single", 32'(wbs_ack | wbs_err), 0);
    check("dc_resp_done", exp_q.size(), 0);
    next_cycle();

    // release back to RUN, write passes straight through
    rm_decouple = 1'b0;
    next_cycle();
    @(negedge clk);
    check("rl_state", 32'(dbg_state), 32'(RUN));
    check("rl_decoupled", 32'(decoupled), 0);
    check("rl_shutdown_ack", 32'(rm_shutdown_ack), 0);
    next_cycle();
    rm_lat = 2;
    exp_q.push_back({1'b1, 1'b0, rm_data(28'h204)});
    wb_req(28'h204, 1'b1, 32'hCAFE_F00D);
    check("rl_stb_fwd", 32'(acc_stb), 1);
    check("rl_we_fwd", 32'(acc_we), 1);
    check("rl_adr_fwd", 32'(acc_adr), 32'h204);
    check("rl_dat_fwd", acc_dat, 32'hCAFE_F00D);
    wait_resp(10);

    // outstanding limit, then asynchronous reset mid-drain
    rm_hold = 1'b1;
    rm_lat = 1;
    for (int i = 0; i < 4; i++) wb_req(28'h400 + 28'(i), 1'b0, 32'h0);
    wbs_stb = 1'b1; wbs_adr = 28'h404; wbs_we = 1'b0;
    @(negedge clk);
    check("lim_stall", 32'(wbs_stall), 1);
    check("lim_stb_gated", 32'(wbm_stb_o), 0);
    check("lim_outst", 32'(dbg_outst), 4);
    next_cycle();
    wbs_stb = 1'b0;
    rm_shutdown_req = 1'b1;
    next_cycle();
    @(negedge clk);
    check("lim_state_drain", 32'(dbg_state), 32'(DRAIN));
    #2;
    rm_flush = 1'b1;
    rst_n = 1'b0;
    #1;
    check("ar_state", 32'(dbg_state), 32'(RUN));
    check("ar_outst", 32'(dbg_outst), 0);
    check("ar_stall", 32'(wbs_stall), 0);
    check("ar_shutdown_ack", 32'(rm_shutdown_ack), 0);
    wbs_cyc = 1'b0;
    rm_shutdown_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rm_flush = 1'b0;
    rm_hold = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("end_state", 32'(dbg_state), 32'(RUN));
    check("end_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
